// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage that sits directly after the execute ALU. It takes one
// load or store request, runs a single transaction on a req/ack data bus, and
// returns sign/zero-extended load data or a store completion to writeback.
// The pipeline stalls while busy is high.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : a misaligned halfword/word is faulted without touching the bus
//   undefined : misaligned low address bits are ignored (H uses addr[1],
//               W uses lane 0) and the access proceeds normally
//
// Parameters
//   TIMEOUT    cycles spent in REQ without mem_ack before aborting (1..65535)
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request strobe, only looked at while idle
//   is_load/is_store  request direction (exactly one must be set)
//   funct3            RV32I width/sign encoding (B, H, W, BU, HU)
//   addr, wdata       effective address and store data
//   busy              high whenever a request is being worked on
//   done              one-cycle completion pulse
//   rdata             extended load data while done is high, otherwise 0
//   fault             qualifies done: illegal, misaligned (trap build) or timeout
//   mem_req..mem_wdata bus request side, held stable until mem_ack
//   mem_rdata,mem_ack bus response side
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [15:0] timer;
   logic [1:0]  addr_lo_q;
   logic [2:0]  funct3_q;
   logic        is_load_q;
   logic        fault_q;
   logic [31:0] rdata_q;

   logic        req_illegal;
   logic        req_misalign;
   logic        req_fault;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_fmt;
   logic        timeout_hit;

   // Decode whether the incoming request can ever reach the bus. Both or
   // neither direction bits, the unused funct3 codes, and unsigned stores
   // (SBU/SHU do not exist) are all rejected.
   always_comb begin
      req_illegal = (is_load == is_store);
      case (funct3)
         3'b000, 3'b001, 3'b010: ;
         3'b100, 3'b101: if (is_store) req_illegal = 1'b1;
         default:        req_illegal = 1'b1;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
   assign req_misalign = 1'b0;
`endif

   assign req_fault = req_illegal | req_misalign;

   // Byte-lane enables and replicated store data for the incoming request.
   // Replicating the data means the memory never has to shift anything;
   // it just writes whichever lanes are enabled.
   always_comb begin
      be_calc    = 4'b0000;
      wdata_calc = 32'h0;
      case (funct3[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_calc    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata[15:0]}};
         end
         2'b10: begin
            be_calc    = 4'b1111;
            wdata_calc = wdata;
         end
         default: ;
      endcase
   end

   // Pull the addressed byte/halfword out of the returned word and extend
   // it according to the latched funct3 (bit 2 set means unsigned).
   always_comb begin
      lane_byte = mem_rdata[{addr_lo_q, 3'b000} +: 8];
      lane_half = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_fmt = {24'h0, lane_byte};
         3'b101:  load_fmt = {16'h0, lane_half};
         default: load_fmt = mem_rdata;
      endcase
   end

   // The timer counts completed REQ cycles without an ack, so comparing with
   // TIMEOUT-1 keeps mem_req up for exactly TIMEOUT cycles.
   assign timeout_hit = (timer == 16'(TIMEOUT - 1));

   // Next-state logic. An ack in the same cycle as the timeout wins.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (start) state_next = req_fault ? S_RESP : S_REQ;
         S_REQ:  if (mem_ack || timeout_hit) state_next = S_RESP;
         S_RESP: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State register plus the request/response datapath. Bus fields are
   // captured once at acceptance so they stay stable for the whole REQ
   // phase even if the requester changes its inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         timer     <= 16'h0;
         addr_lo_q <= 2'b00;
         funct3_q  <= 3'b000;
         is_load_q <= 1'b0;
         fault_q   <= 1'b0;
         rdata_q   <= 32'h0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'h0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (start) begin
                  timer     <= 16'h0;
                  addr_lo_q <= addr[1:0];
                  funct3_q  <= funct3;
                  is_load_q <= is_load;
                  fault_q   <= req_fault;
                  rdata_q   <= 32'h0;
                  mem_we    <= is_store & ~req_fault;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_be    <= req_fault ? 4'b0000 : be_calc;
                  mem_wdata <= req_fault ? 32'h0 : wdata_calc;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  rdata_q <= is_load_q ? load_fmt : 32'h0;
               end else begin
                  timer <= timer + 16'd1;
                  if (timeout_hit) fault_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state != S_IDLE);
   assign done    = (state == S_RESP);
   assign mem_req = (state == S_REQ);
   assign fault   = done & fault_q;
   assign rdata   = done ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives directed and random load/store requests into load_store_unit, acts
// as the data memory (ack after a chosen number of REQ cycles), and compares
// the observed bus fields, latency and results with a byte-level reference
// model of RV32I load/store semantics.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        fault;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit          ld;
      bit          st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;
      int          delay;
   } txn_t;

   typedef struct {
      bit          fault;
      int          done_cycle;
      int          req_cycles;
      logic        we;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      bit          hung;
      int          done_cycle;
      int          req_cycles;
      bit          stable;
      logic        we;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [31:0] rdata;
      logic        fault;
      logic        done_after;
      logic        busy_after;
   } obs_t;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_load   (is_load),
      .is_store  (is_store),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .fault     (fault),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   // Reference model: access size in bytes, lane offset, replicated store
   // bytes and shifted/masked load value, plus expected cycle counts.
   function automatic exp_t model(input txn_t t);
      exp_t        e;
      int          size;
      int          off;
      bit          legal;
      logic [31:0] v;
      logic [31:0] mask;
      e = '{default: 0};
      size  = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
      legal = (t.ld != t.st) && (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) &&
              !(t.st && t.f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
      if (size > 1 && (int'(t.addr[1:0]) % size) != 0) legal = 1'b0;
`endif
      if (!legal) begin
         e.fault      = 1'b1;
         e.done_cycle = 1;
         return e;
      end
      off      = int'(t.addr[1:0]) / size * size;
      e.be     = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = t.wdata[8*(i % size) +: 8];
      e.maddr  = t.addr & ~32'h3;
      e.we     = t.st;
      if (t.delay >= TO) begin
         e.req_cycles = TO;
         e.done_cycle = TO + 1;
         e.fault      = 1'b1;
         return e;
      end
      e.req_cycles = t.delay + 1;
      e.done_cycle = t.delay + 2;
      if (t.ld) begin
         v = t.mrd >> (8 * off);
         if (size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            v    = v & mask;
            if (!t.f3[2] && v[8*size-1]) v = v | ~mask;
         end
         e.rdata = v;
      end
      return e;
   endfunction

   // Issues one request from an idle DUT and plays the memory. While busy it
   // keeps toggling start with junk fields, which the DUT must ignore.
   task automatic applyStimulus(input txn_t t, output obs_t o);
      bit first;
      o        = '{default: 0};
      o.hung   = 1'b1;
      o.stable = 1'b1;
      first    = 1'b1;
      start    = 1'b1;
      is_load  = t.ld;
      is_store = t.st;
      funct3   = t.f3;
      addr     = t.addr;
      wdata    = t.wdata;
      mem_ack  = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         start     = 1'($urandom_range(0, 1));
         is_load   = 1'($urandom_range(0, 1));
         is_store  = 1'($urandom_range(0, 1));
         funct3    = 3'($urandom_range(0, 7));
         addr      = $urandom;
         wdata     = $urandom;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (done) begin
            start        = 1'b0;
            o.done_cycle = c;
            o.rdata      = rdata;
            o.fault      = fault;
            o.hung       = 1'b0;
            break;
         end
         if (mem_req) begin
            if (first) begin
               o.we     = mem_we;
               o.be     = mem_be;
               o.maddr  = mem_addr;
               o.mwdata = mem_wdata;
               first    = 1'b0;
            end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== {o.we, o.be, o.maddr, o.mwdata}) begin
               o.stable = 1'b0;
            end
            if (o.req_cycles == t.delay) begin
               mem_ack   = 1'b1;
               mem_rdata = t.mrd;
            end
            o.req_cycles++;
         end
      end
      @(posedge clk); #1;
      o.done_after = done;
      o.busy_after = busy;
      start   = 1'b0;
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
      funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
      mem_rdata = 32'h0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, fault, mem_req, mem_we} !== 5'b00000) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, fault, mem_req, mem_we});
      end
      n_checks++;
      if (rdata !== 32'h0) begin
         n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata);
      end
      n_checks++;
      if (mem_addr !== 32'h0) begin
         n_fail++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr);
      end
      n_checks++;
      if (mem_be !== 4'h0) begin
         n_fail++; $display("[TB] FAIL reset_mem_be: got %b expected 0000", mem_be);
      end
      n_checks++;
      if (mem_wdata !== 32'h0) begin
         n_fail++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", mem_wdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_transactions(input string tag, input txn_t q[$]);
      exp_t e;
      obs_t o;
      foreach (q[i]) begin
         e = model(q[i]);
         applyStimulus(q[i], o);
         n_checks++;
         if (o.hung) begin
            n_fail++; $display("[TB] FAIL %s#%0d done_wait: got no done in 30 cycles expected done", tag, i);
         end
         n_checks++;
         if (o.done_cycle != e.done_cycle) begin
            n_fail++; $display("[TB] FAIL %s#%0d done_cycle: got %0d expected %0d", tag, i, o.done_cycle, e.done_cycle);
         end
         n_checks++;
         if (o.req_cycles != e.req_cycles) begin
            n_fail++; $display("[TB] FAIL %s#%0d req_cycles: got %0d expected %0d", tag, i, o.req_cycles, e.req_cycles);
         end
         n_checks++;
         if (o.fault !== e.fault) begin
            n_fail++; $display("[TB] FAIL %s#%0d fault: got %b expected %b", tag, i, o.fault, e.fault);
         end
         n_checks++;
         if (o.rdata !== e.rdata) begin
            n_fail++; $display("[TB] FAIL %s#%0d rdata: got %h expected %h", tag, i, o.rdata, e.rdata);
         end
         n_checks++;
         if ({o.done_after, o.busy_after} !== 2'b00) begin
            n_fail++; $display("[TB] FAIL %s#%0d after_done: got done,busy=%b expected 00", tag, i, {o.done_after, o.busy_after});
         end
         if (e.req_cycles > 0) begin
            n_checks++;
            if ({o.we, o.be} !== {e.we, e.be}) begin
               n_fail++; $display("[TB] FAIL %s#%0d we_be: got %b/%b expected %b/%b", tag, i, o.we, o.be, e.we, e.be);
            end
            n_checks++;
            if (o.maddr !== e.maddr) begin
               n_fail++; $display("[TB] FAIL %s#%0d mem_addr: got %h expected %h", tag, i, o.maddr, e.maddr);
            end
            n_checks++;
            if (o.mwdata !== e.mwdata) begin
               n_fail++; $display("[TB] FAIL %s#%0d mem_wdata: got %h expected %h", tag, i, o.mwdata, e.mwdata);
            end
            n_checks++;
            if (!o.stable) begin
               n_fail++; $display("[TB] FAIL %s#%0d bus_stable: got changing bus fields expected stable", tag, i);
            end
         end
      end
   endtask

   task automatic test_timeout();
      txn_t t;
      obs_t o;
      t = '{ld: 1'b1, st: 1'b0, f3: 3'b010, addr: 32'h40, wdata: 32'h0, mrd: 32'h0, delay: 1000};
      applyStimulus(t, o);
      n_checks++;
      if (o.req_cycles != TO) begin
         n_fail++; $display("[TB] FAIL timeout_req_cycles: got %0d expected %0d", o.req_cycles, TO);
      end
      n_checks++;
      if (o.fault !== 1'b1 || o.done_cycle != TO + 1) begin
         n_fail++; $display("[TB] FAIL timeout_done: got fault=%b at %0d expected fault=1 at %0d", o.fault, o.done_cycle, TO + 1);
      end
      // Late ack while idle must not produce anything.
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      n_checks++;
      if ({busy, done, mem_req} !== 3'b000) begin
         n_fail++; $display("[TB] FAIL late_ack: got busy,done,req=%b expected 000", {busy, done, mem_req});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      txn_t t;
      obs_t o;
      start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
      addr = 32'h80; mem_ack = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (mem_req !== 1'b1) begin
         n_fail++; $display("[TB] FAIL rst_mid_req: got %b expected 1", mem_req);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      n_checks++;
      if ({mem_req, busy, done} !== 3'b000) begin
         n_fail++; $display("[TB] FAIL rst_mid_state: got req,busy,done=%b expected 000", {mem_req, busy, done});
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      n_checks++;
      if ({mem_req, busy, done} !== 3'b000) begin
         n_fail++; $display("[TB] FAIL rst_mid_stale_ack: got req,busy,done=%b expected 000", {mem_req, busy, done});
      end
      t = '{ld: 1'b1, st: 1'b0, f3: 3'b010, addr: 32'h84, wdata: 32'h0, mrd: 32'h1234_5678, delay: 0};
      applyStimulus(t, o);
      n_checks++;
      if (o.done_cycle != 2 || o.rdata !== 32'h1234_5678 || o.fault !== 1'b0) begin
         n_fail++; $display("[TB] FAIL rst_mid_restart: got cycle=%0d rdata=%h fault=%b expected 2/12345678/0", o.done_cycle, o.rdata, o.fault);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      txn_t dq[$];
      txn_t rq[$];
      txn_t t;
      test_reset();

      dq.push_back('{ld: 1'b1, st: 1'b0, f3: 3'b010, addr: 32'h100, wdata: 32'h0,        mrd: 32'hDEADBEEF, delay: 0});
      dq.push_back('{ld: 1'b1, st: 1'b0, f3: 3'b000, addr: 32'h203, wdata: 32'h0,        mrd: 32'h80112233, delay: 0});
      dq.push_back('{ld: 1'b1, st: 1'b0, f3: 3'b100, addr: 32'h203, wdata: 32'h0,        mrd: 32'h80112233, delay: 0});
      dq.push_back('{ld: 1'b0, st: 1'b1, f3: 3'b001, addr: 32'h302, wdata: 32'h0000ABCD, mrd: 32'h0,        delay: 1});
      dq.push_back('{ld: 1'b1, st: 1'b0, f3: 3'b001, addr: 32'h101, wdata: 32'h0,        mrd: 32'h5A5A8001, delay: 0});
      dq.push_back('{ld: 1'b1, st: 1'b0, f3: 3'b101, addr: 32'h102, wdata: 32'h0,        mrd: 32'h9876ABCD, delay: 2});
      dq.push_back('{ld: 1'b1, st: 1'b0, f3: 3'b010, addr: 32'h103, wdata: 32'h0,        mrd: 32'h01020304, delay: 0});
      dq.push_back('{ld: 1'b0, st: 1'b1, f3: 3'b000, addr: 32'h401, wdata: 32'h123456EF, mrd: 32'h0,        delay: TO - 1});
      dq.push_back('{ld: 1'b1, st: 1'b1, f3: 3'b010, addr: 32'h10,  wdata: 32'h0,        mrd: 32'h0,        delay: 0});
      dq.push_back('{ld: 1'b0, st: 1'b0, f3: 3'b010, addr: 32'h10,  wdata: 32'h0,        mrd: 32'h0,        delay: 0});
      dq.push_back('{ld: 1'b1, st: 1'b0, f3: 3'b011, addr: 32'h10,  wdata: 32'h0,        mrd: 32'h0,        delay: 0});
      dq.push_back('{ld: 1'b0, st: 1'b1, f3: 3'b100, addr: 32'h10,  wdata: 32'h0,        mrd: 32'h0,        delay: 0});
      test_transactions("directed", dq);

      for (int i = 0; i < 40; i++) begin
         t.ld = 1'($urandom_range(0, 1));
         t.st = ~t.ld;
         if ($urandom_range(0, 9) == 0) t.st = t.ld;
         case ($urandom_range(0, 5))
            0: t.f3 = 3'd0;
            1: t.f3 = 3'd1;
            2: t.f3 = 3'd2;
            3: t.f3 = 3'd4;
            4: t.f3 = 3'd5;
            default: t.f3 = 3'($urandom_range(0, 7));
         endcase
         t.addr  = $urandom;
         t.wdata = $urandom;
         t.mrd   = $urandom;
         t.delay = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(TO, TO + 2));
         rq.push_back(t);
      end
      test_transactions("random", rq);

      test_timeout();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
